// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Status reads are registered to line up with data-memory load latency.
module uart_tx_periph #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [9:0]  DATA_ADDR    = 10'h54,
    parameter logic [9:0]  STAT_ADDR    = 10'h58
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] address,
    input  logic [7:0] data,
    input  logic       write,
    output logic [7:0] read_data,
    output logic       tx,
    output logic       busy
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [NW-1:0] count_q;
    logic          ovf_q, ovf_d;
    logic [7:0]    rd_q;

    logic       full, empty, baud_end;
    logic       push_req, push, pop, clr_ovf;
    logic [7:0] status;

    assign full     = (count_q == NW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign baud_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign push_req = write && (address == DATA_ADDR);
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push     = push_req && (!full || pop);
    assign clr_ovf  = write && (address == STAT_ADDR) && data[3];
    assign status   = {4'h0, ovf_q, (state_q != IDLE), empty, full};

    assign busy      = !empty || (state_q != IDLE);
    assign read_data = rd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (baud_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    cnt_d = '0;
                    // Chain straight into the next frame when data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            rd_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_q + NW'(push) - NW'(pop);
            ovf_q   <= ovf_d;
            rd_q    <= (address == STAT_ADDR) ? status : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= data;
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: frame-level reference model, sampling
// receiver and directed stimulus with hand-computed expectations.
module tb_uart_tx_periph;
    localparam int C      = 4;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 10 * C;
    localparam logic [9:0] DATA_A = 10'h54;
    localparam logic [9:0] STAT_A = 10'h58;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] address = '0;
    logic [7:0] data = '0;
    logic       write = 1'b0;
    logic [7:0] read_data;
    logic       tx;
    logic       busy;

    uart_tx_periph #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH(DEPTH),
        .DATA_ADDR(DATA_A),
        .STAT_ADDR(STAT_A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .data(data),
        .write(write),
        .read_data(read_data),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus position within the current frame.
    logic [7:0] mq[$];
    logic [7:0] done_q[$];
    bit         m_act = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = '0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_rd = '0;
    int         m_sz;
    bit         m_full, m_pop, m_acc;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_act = 1'b0;
            m_t   = 0;
            m_ovf = 1'b0;
            m_rd  = 8'h00;
        end else begin
            m_sz   = mq.size();
            m_full = (m_sz == DEPTH);
            m_rd   = (address == STAT_A) ?
                     {4'h0, m_ovf, m_act, (m_sz == 0), m_full} : 8'h00;
            m_pop  = (m_sz > 0) && (!m_act || m_t == FRAME - 1);
            m_acc  = write && (address == DATA_A) && (!m_full || m_pop);
            if (write && address == STAT_A && data[3]) m_ovf = 1'b0;
            if (write && address == DATA_A && !m_acc) m_ovf = 1'b1;
            if (m_act && m_t == FRAME - 1) done_q.push_back(m_cur);
            if (m_pop) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_t   = 0;
            end else if (m_act) begin
                if (m_t == FRAME - 1) m_act = 1'b0;
                else m_t++;
            end
            if (m_acc) mq.push_back(data);
        end
    end

    function automatic logic exp_tx();
        if (!m_act) return 1'b1;
        if (m_t < C) return 1'b0;
        if (m_t < 9 * C) return m_cur[(m_t - C) / C];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx", tx, exp_tx());
            chk("busy", busy, (mq.size() > 0) || m_act);
            chk("read_data", read_data, m_rd);
        end
    end

    // Sampling receiver: mid-bit samples after a detected start edge.
    logic [7:0] rx_q[$];
    bit         rx_on = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = '0;
    logic       rx_prev = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            rx_on = 1'b0;
        end else if (rx_on) begin
            rx_t++;
            if (rx_t > C && rx_t < 9 * C && rx_t % C == C / 2)
                rx_sh = {tx, rx_sh[7:1]};
            if (rx_t == 9 * C + C / 2) begin
                chk("rx_stop", tx, 1);
                rx_q.push_back(rx_sh);
                rx_on = 1'b0;
            end
        end else if (rx_prev === 1'b1 && tx === 1'b0) begin
            rx_on = 1'b1;
            rx_t  = 0;
        end
        rx_prev = tx;
    end

    task automatic push(input logic [7:0] b);
        @(posedge clk); #1;
        address = DATA_A; data = b; write = 1'b1;
        @(posedge clk); #1;
        address = '0; write = 1'b0;
    endtask

    task automatic push_seq(input int n, input logic [7:0] base);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            address = DATA_A; data = base + 8'(i); write = 1'b1;
            @(posedge clk); #1;
        end
        address = '0; write = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [7:0] v);
        @(posedge clk); #1;
        address = a;
        @(posedge clk); #1;
        address = '0;
        @(negedge clk);
        v = read_data;
    endtask

    task automatic wr_stat(input logic [7:0] d);
        @(posedge clk); #1;
        address = STAT_A; data = d; write = 1'b1;
        @(posedge clk); #1;
        address = '0; write = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (!busy) break;
            if (n >= max) begin
                n_checks++;
                n_err++;
                $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
                break;
            end
        end
    endtask

    logic [7:0] v;
    int         n, rx0;
    logic       txs [1:42];
    logic       bs  [1:42];
    bit         a5_bits [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        a5_bits = '{1, 0, 1, 0, 0, 1, 0, 1};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        repeat (50) @(negedge clk);
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);
        chk("idle_rd", read_data, 8'h00);
        rd(STAT_A, v);
        chk("reset_status", v, 8'h02);

        push(8'hA5);
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            txs[k] = tx;
            bs[k]  = busy;
        end
        chk("a5_pre", txs[1], 1);
        for (int k = 2; k <= 5; k++) chk("a5_start", txs[k], 0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < C; j++)
                chk("a5_bit", txs[6 + C * i + j], a5_bits[i]);
        for (int k = 38; k <= 41; k++) chk("a5_stop", txs[k], 1);
        chk("a5_busy_last", bs[41], 1);
        chk("a5_busy_drop", bs[42], 0);
        chk("a5_rx", (rx_q.size() > 0) ? rx_q[rx_q.size() - 1] : 8'hxx, 8'hA5);

        rx0 = rx_q.size();
        push_seq(5, 8'h01);
        wait_idle(400, n);
        chk("b2b_cycles", n, 198);
        chk("b2b_count", rx_q.size() - rx0, 5);
        for (int i = 0; i < 5; i++)
            chk("b2b_byte", rx_q[rx0 + i], 8'h01 + 8'(i));
        rd(STAT_A, v);
        chk("b2b_status", v, 8'h02);

        rx0 = rx_q.size();
        push_seq(6, 8'hA1);
        rd(STAT_A, v);
        chk("ovf_status", v, 8'h0D);
        wr_stat(8'h08);
        rd(STAT_A, v);
        chk("ovf_cleared", v, 8'h05);
        wait_idle(400, n);
        chk("ovf_count", rx_q.size() - rx0, 5);
        for (int i = 0; i < 5; i++)
            chk("ovf_byte", rx_q[rx0 + i], 8'hA1 + 8'(i));

        push_seq(3, 8'h11);
        repeat (12) @(posedge clk);
        rx0 = rx_q.size();
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        rd(STAT_A, v);
        chk("rst_status", v, 8'h02);
        repeat (60) @(negedge clk);
        chk("rst_no_frames", rx_q.size() - rx0, 0);
        push(8'h3C);
        wait_idle(100, n);
        chk("rst_new_count", rx_q.size() - rx0, 1);
        chk("rst_new_byte", (rx_q.size() > 0) ? rx_q[rx_q.size() - 1] : 8'hxx, 8'h3C);

        @(posedge clk); #1;
        address = 10'h50; data = 8'hFF; write = 1'b1;
        @(posedge clk); #1;
        address = 10'h55;
        @(posedge clk); #1;
        address = '0; write = 1'b0;
        repeat (20) @(negedge clk);
        chk("badaddr_tx", tx, 1);
        chk("badaddr_busy", busy, 0);
        rd(STAT_A, v);
        chk("badaddr_status", v, 8'h02);
        rd(DATA_A, v);
        chk("data_addr_read", v, 8'h00);

        repeat (5) @(negedge clk);
        chk("rx_total", rx_q.size(), done_q.size());
        for (int i = 0; i < rx_q.size() && i < done_q.size(); i++)
            chk("rx_vs_model", rx_q[i], done_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
